entry_alloc_decoder: RTL and testbench

Index-to-one-hot decoder with entry-occupancy tracking. It is the companion to the entry search encoder, which produces an index from a request bitmap. This block takes the selected index back, decodes it to one-hot, marks that entry busy, and clears entries on release. It sits between the entry allocator and the entry table, supplying the busy bitmap that feeds the next search cycle.

---
 rtl/entry_alloc_decoder_if.sv | 30 +++
 rtl/entry_alloc_decoder.sv | 85 ++++++++
 tb/tb_entry_alloc_decoder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/entry_alloc_decoder_if.sv
// Request/status bundle between the entry allocator (master) and the
// occupancy decoder (slave).
interface entry_alloc_decoder_if #(
  parameter int ENTSEL = 2,
  parameter int ENTNUM = 4
);
  logic              alloc_valid;
  logic [ENTSEL-1:0] alloc_idx;
  logic              free_valid;
  logic [ENTSEL-1:0] free_idx;
  logic              err_clr;
  logic [ENTNUM-1:0] busy;
  logic [ENTNUM-1:0] alloc_onehot;
  logic              alloc_done;
  logic [ENTSEL:0]   busy_cnt;
  logic              full;
  logic              empty;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output alloc_valid, alloc_idx, free_valid, free_idx, err_clr,
    input  busy, alloc_onehot, alloc_done, busy_cnt, full, empty, err, err_code
  );

  modport slave (
    input  alloc_valid, alloc_idx, free_valid, free_idx, err_clr,
    output busy, alloc_onehot, alloc_done, busy_cnt, full, empty, err, err_code
  );
endinterface

// File: rtl/entry_alloc_decoder.sv
// Decodes an allocated entry index to one-hot, tracks the busy bitmap and
// count, and flags illegal alloc/free requests with a sticky error.
module entry_alloc_decoder #(
  parameter int ENTSEL = 2,
  parameter int ENTNUM = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  entry_alloc_decoder_if.slave bus
);
  localparam logic [ENTSEL:0] NUM = (ENTSEL+1)'(ENTNUM);

  logic [ENTNUM-1:0] busy_q, onehot_q, busy_mid, busy_next;
  logic [ENTNUM-1:0] alloc_dec, free_dec;
  logic [ENTSEL:0]   cnt_q, cnt_next;
  logic              done_q, full_q, empty_q, err_q;
  logic [1:0]        code_q, err_code_now;
  logic              alloc_ok, free_ok, acc_alloc, acc_free;
  logic              e_range, e_idle, e_busy;

  // Out-of-range indices decode to zero, so they can never hit a busy bit.
  always_comb begin
    alloc_dec = '0;
    free_dec  = '0;
    for (int i = 0; i < ENTNUM; i++) begin
      alloc_dec[i] = (bus.alloc_idx == ENTSEL'(i));
      free_dec[i]  = (bus.free_idx == ENTSEL'(i));
    end
  end

  always_comb begin
    alloc_ok  = ({1'b0, bus.alloc_idx} < NUM);
    free_ok   = ({1'b0, bus.free_idx} < NUM);
    acc_free  = bus.free_valid && free_ok && |(free_dec & busy_q);
    busy_mid  = acc_free ? (busy_q & ~free_dec) : busy_q;
    acc_alloc = bus.alloc_valid && alloc_ok && |(alloc_dec & ~busy_mid);
    busy_next = acc_alloc ? (busy_mid | alloc_dec) : busy_mid;
    cnt_next  = cnt_q + {{ENTSEL{1'b0}}, acc_alloc} - {{ENTSEL{1'b0}}, acc_free};

    e_range = (bus.alloc_valid && !alloc_ok) || (bus.free_valid && !free_ok);
    e_idle  = bus.free_valid && free_ok && !acc_free;
    e_busy  = bus.alloc_valid && alloc_ok && !acc_alloc;
    if (e_range)      err_code_now = 2'b11;
    else if (e_idle)  err_code_now = 2'b10;
    else if (e_busy)  err_code_now = 2'b01;
    else              err_code_now = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      onehot_q <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      busy_q  <= busy_next;
      done_q  <= acc_alloc;
      cnt_q   <= cnt_next;
      full_q  <= (cnt_next == NUM);
      empty_q <= (cnt_next == '0);
      if (acc_alloc) onehot_q <= alloc_dec;
      // A new error beats a simultaneous clear; otherwise the first cause sticks.
      if (err_code_now != 2'b00) begin
        err_q <= 1'b1;
        if (!err_q || bus.err_clr) code_q <= err_code_now;
      end else if (bus.err_clr) begin
        err_q  <= 1'b0;
        code_q <= 2'b00;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.alloc_onehot = onehot_q;
  assign bus.alloc_done   = done_q;
  assign bus.busy_cnt     = cnt_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.err          = err_q;
  assign bus.err_code     = code_q;
endmodule

// File: tb/tb_entry_alloc_decoder.sv
// Directed bench for entry_alloc_decoder: a 4-entry instance and a
// 3-entry instance (non-power-of-two) share clock and reset.
module tb_entry_alloc_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  entry_alloc_decoder_if #(.ENTSEL(2), .ENTNUM(4)) bus4 ();
  entry_alloc_decoder_if #(.ENTSEL(2), .ENTNUM(3)) bus3 ();

  entry_alloc_decoder #(.ENTSEL(2), .ENTNUM(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  entry_alloc_decoder #(.ENTSEL(2), .ENTNUM(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleAll();
    bus4.alloc_valid = 0; bus4.alloc_idx = 0; bus4.free_valid = 0; bus4.free_idx = 0; bus4.err_clr = 0;
    bus3.alloc_valid = 0; bus3.alloc_idx = 0; bus3.free_valid = 0; bus3.free_idx = 0; bus3.err_clr = 0;
  endtask

  // Present one cycle of requests to the chosen instance, then sample just after the edge.
  task automatic applyStimulus(input bit to3, input bit av, input logic [1:0] ai,
                               input bit fv, input logic [1:0] fi, input bit clr);
    if (to3) begin
      bus3.alloc_valid = av; bus3.alloc_idx = ai; bus3.free_valid = fv; bus3.free_idx = fi; bus3.err_clr = clr;
    end else begin
      bus4.alloc_valid = av; bus4.alloc_idx = ai; bus4.free_valid = fv; bus4.free_idx = fi; bus4.err_clr = clr;
    end
    @(posedge clk);
    #1;
    idleAll();
  endtask

  initial begin
    idleAll();
    #12;
    checkOutput("rst_busy", bus4.busy, 4'b0000);
    checkOutput("rst_onehot", bus4.alloc_onehot, 4'b0000);
    checkOutput("rst_done", bus4.alloc_done, 0);
    checkOutput("rst_cnt", bus4.busy_cnt, 0);
    checkOutput("rst_full", bus4.full, 0);
    checkOutput("rst_empty", bus4.empty, 1);
    checkOutput("rst_err", bus4.err, 0);
    checkOutput("rst_code", bus4.err_code, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 3-entry instance: index 3 is out of range
    applyStimulus(1, 1, 2'd3, 0, 2'd0, 0);
    checkOutput("n3_range_err", bus3.err, 1);
    checkOutput("n3_range_code", bus3.err_code, 2'b11);
    checkOutput("n3_range_busy", bus3.busy, 3'b000);
    checkOutput("n3_range_cnt", bus3.busy_cnt, 0);
    checkOutput("n3_range_done", bus3.alloc_done, 0);
    applyStimulus(1, 0, 2'd0, 0, 2'd0, 1);
    checkOutput("n3_clr_err", bus3.err, 0);
    checkOutput("n3_clr_code", bus3.err_code, 0);
    applyStimulus(1, 1, 2'd3, 1, 2'd0, 0);
    checkOutput("n3_prec_code", bus3.err_code, 2'b11);
    applyStimulus(1, 1, 2'd2, 0, 2'd0, 1);
    checkOutput("n3_a2_busy", bus3.busy, 3'b100);
    checkOutput("n3_a2_err", bus3.err, 0);
    applyStimulus(1, 1, 2'd0, 0, 2'd0, 0);
    applyStimulus(1, 1, 2'd1, 0, 2'd0, 0);
    checkOutput("n3_full_busy", bus3.busy, 3'b111);
    checkOutput("n3_full_cnt", bus3.busy_cnt, 3);
    checkOutput("n3_full", bus3.full, 1);

    // 4-entry instance: single alloc and done pulse
    applyStimulus(0, 1, 2'd2, 0, 2'd0, 0);
    checkOutput("a2_busy", bus4.busy, 4'b0100);
    checkOutput("a2_onehot", bus4.alloc_onehot, 4'b0100);
    checkOutput("a2_done", bus4.alloc_done, 1);
    checkOutput("a2_cnt", bus4.busy_cnt, 1);
    checkOutput("a2_empty", bus4.empty, 0);
    applyStimulus(0, 0, 2'd0, 0, 2'd0, 0);
    checkOutput("idle_done", bus4.alloc_done, 0);
    checkOutput("idle_onehot", bus4.alloc_onehot, 4'b0100);
    applyStimulus(0, 0, 2'd0, 1, 2'd2, 0);
    checkOutput("f2_busy", bus4.busy, 4'b0000);
    checkOutput("f2_empty", bus4.empty, 1);

    // fill all four, then alloc a busy entry
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 2'(i), 0, 2'd0, 0);
    checkOutput("fill_busy", bus4.busy, 4'b1111);
    checkOutput("fill_cnt", bus4.busy_cnt, 4);
    checkOutput("fill_full", bus4.full, 1);
    checkOutput("fill_onehot", bus4.alloc_onehot, 4'b1000);
    applyStimulus(0, 1, 2'd1, 0, 2'd0, 0);
    checkOutput("dup_err", bus4.err, 1);
    checkOutput("dup_code", bus4.err_code, 2'b01);
    checkOutput("dup_busy", bus4.busy, 4'b1111);
    checkOutput("dup_done", bus4.alloc_done, 0);
    checkOutput("dup_cnt", bus4.busy_cnt, 4);
    applyStimulus(0, 0, 2'd0, 0, 2'd0, 1);
    checkOutput("clr1_err", bus4.err, 0);

    // free down to 0010, then free+alloc entry 1 together
    applyStimulus(0, 0, 2'd0, 1, 2'd0, 0);
    applyStimulus(0, 0, 2'd0, 1, 2'd2, 0);
    applyStimulus(0, 0, 2'd0, 1, 2'd3, 0);
    checkOutput("pre_swap_busy", bus4.busy, 4'b0010);
    checkOutput("pre_swap_full", bus4.full, 0);
    applyStimulus(0, 1, 2'd1, 1, 2'd1, 0);
    checkOutput("swap_busy", bus4.busy, 4'b0010);
    checkOutput("swap_cnt", bus4.busy_cnt, 1);
    checkOutput("swap_done", bus4.alloc_done, 1);
    checkOutput("swap_onehot", bus4.alloc_onehot, 4'b0010);
    checkOutput("swap_err", bus4.err, 0);

    // free of idle entry, clear, and clear racing a new error
    applyStimulus(0, 0, 2'd0, 1, 2'd1, 0);
    applyStimulus(0, 0, 2'd0, 1, 2'd3, 0);
    checkOutput("idle_free_err", bus4.err, 1);
    checkOutput("idle_free_code", bus4.err_code, 2'b10);
    checkOutput("idle_free_cnt", bus4.busy_cnt, 0);
    applyStimulus(0, 0, 2'd0, 0, 2'd0, 1);
    checkOutput("clr2_err", bus4.err, 0);
    checkOutput("clr2_code", bus4.err_code, 0);
    applyStimulus(0, 0, 2'd0, 1, 2'd3, 1);
    checkOutput("clr_race_err", bus4.err, 1);
    checkOutput("clr_race_code", bus4.err_code, 2'b10);
    applyStimulus(0, 1, 2'd0, 0, 2'd0, 0);
    applyStimulus(0, 1, 2'd0, 0, 2'd0, 0);
    checkOutput("first_wins_code", bus4.err_code, 2'b10);
    applyStimulus(0, 0, 2'd0, 1, 2'd0, 1);
    checkOutput("clr3_err", bus4.err, 0);

    // async reset mid-cycle from busy=1011
    applyStimulus(0, 1, 2'd0, 0, 2'd0, 0);
    applyStimulus(0, 1, 2'd1, 0, 2'd0, 0);
    applyStimulus(0, 1, 2'd3, 0, 2'd0, 0);
    checkOutput("pre_rst_busy", bus4.busy, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_busy", bus4.busy, 4'b0000);
    checkOutput("async_cnt", bus4.busy_cnt, 0);
    checkOutput("async_empty", bus4.empty, 1);
    checkOutput("async_n3_busy", bus3.busy, 3'b000);
    #2 rst_n = 1'b1;
    applyStimulus(0, 1, 2'd0, 0, 2'd0, 0);
    checkOutput("post_rst_busy", bus4.busy, 4'b0001);
    checkOutput("post_rst_cnt", bus4.busy_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
